rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_writeback.sv | 179 +++++++++++++++++
 tb/tb_rf_writeback.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
`default_nettype none

// Register-file writeback arbiter with a small in-order mul/div result buffer and busy scoreboard.
// Latency: ALU result written one cycle after sampling; mul/div result at least two cycles after handshake.
// Backpressure: ALU is never stalled; mul/div is throttled only through md_ready (buffer full).
module rf_writeback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        stall,
    output logic [4:0]  wR,
    output logic [31:0] wD,
    output logic        rf_we
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } md_ent_t;

    localparam int ENT_W = $bits(md_ent_t);

    logic          alu_req;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_rdy;
    logic          fifo_vld;
    md_ent_t       push_ent;
    md_ent_t       head;
    logic [31:0]   busy;
    logic [31:0]   busy_nxt;

    assign alu_req  = alu_valid && (alu_rd != 5'd0);
    assign md_ready = fifo_rdy;

    // Writes to x0 are accepted on the handshake but never buffered.
    assign fifo_push = md_valid && fifo_rdy && (md_rd != 5'd0);
    assign fifo_pop  = !alu_req && fifo_vld;

    assign push_ent.rd   = md_rd;
    assign push_ent.data = md_data;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_md_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (fifo_push),
        .push_dat (push_ent),
        .push_rdy (fifo_rdy),
        .pop_vld  (fifo_vld),
        .pop_rdy  (fifo_pop),
        .pop_dat  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wR    <= 5'd0;
            wD    <= 32'd0;
            rf_we <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            if (alu_req) begin
                wR    <= alu_rd;
                wD    <= alu_data;
                rf_we <= 1'b1;
            end else if (fifo_vld) begin
                wR    <= head.rd;
                wD    <= head.data;
                rf_we <= 1'b1;
            end
        end
    end

    // Clear first so a same-edge issue to the retiring register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (fifo_pop) begin
            busy_nxt[head.rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign stall = ((chk_rs1 != 5'd0) && busy[chk_rs1]) ||
                   ((chk_rs2 != 5'd0) && busy[chk_rs2]);

endmodule

// Generic synchronous FIFO, show-ahead head, no bypass.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: push_rdy reflects the registered count only, independent of a same-cycle pop.
module rf_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push_rdy = (count < CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback.sv
`timescale 1ns/1ps

module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        stall;
    logic [4:0]  wR;
    logic [31:0] wD;
    logic        rf_we;

    always #5 clk = ~clk;

    rf_writeback #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .md_valid  (md_valid),
        .md_rd     (md_rd),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .stall     (stall),
        .wR        (wR),
        .wD        (wD),
        .rf_we     (rf_we)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    // Reference: pending mul/div results, expected register writes, busy set.
    ent_t        mq[$];
    ent_t        eq[$];
    bit          mbusy [32];
    logic [4:0]  lrd = 5'd0;
    logic [31:0] ld  = 32'd0;
    int          total = 0;
    int          bad   = 0;
    ent_t        me;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_stall(input logic [4:0] r1, input logic [4:0] r2);
        return (r1 != 0 && mbusy[r1]) || (r2 != 0 && mbusy[r2]);
    endfunction

    // Monitor: every cycle the write port must match the head of the expected-write queue.
    always @(negedge clk) begin
        chk("rf_we", rf_we, eq.size() > 0);
        if (eq.size() > 0) begin
            me = eq.pop_front();
            chk("wR", wR, me.rd);
            chk("wD", wD, me.d);
            lrd = me.rd;
            ld  = me.d;
        end else begin
            chk("wR_hold", wR, lrd);
            chk("wD_hold", wD, ld);
        end
    end

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
        bit   hs;
        ent_t e;
        @(negedge clk);
        #2;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        md_valid = mv;  md_rd = mrd;  md_data = md;
        iss_valid = iv; iss_rd = ird;
        chk_rs1 = r1;   chk_rs2 = r2;
        #1;
        chk("md_ready", md_ready, mq.size() < 2);
        chk("stall", stall, exp_stall(r1, r2));
        hs = mv && (mq.size() < 2);
        if (av && ard != 0) begin
            e.rd = ard; e.d = ad;
            eq.push_back(e);
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            mbusy[e.rd] = 1'b0;
            eq.push_back(e);
        end
        if (hs && mrd != 0) begin
            e.rd = mrd; e.d = md;
            mq.push_back(e);
        end
        if (iv && ird != 0) mbusy[ird] = 1'b1;
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    task automatic mid_reset(input logic [4:0] r1);
        @(negedge clk);
        #2;
        alu_valid = 0; md_valid = 0; iss_valid = 0;
        chk_rs1 = r1; chk_rs2 = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wR", wR, 0);
        chk("rst_wD", wD, 0);
        chk("rst_md_ready", md_ready, 1);
        chk("rst_stall", stall, 0);
        mq.delete();
        eq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        lrd = 5'd0;
        ld  = 32'd0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        md_valid = 0;  md_rd = 0;  md_data = 0;
        iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
        #3;
        chk("init_rf_we", rf_we, 0);
        chk("init_wR", wR, 0);
        chk("init_wD", wD, 0);
        chk("init_md_ready", md_ready, 1);
        chk("init_stall", stall, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Single ALU write
        cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        // Issue, stall, mul/div retire clears stall
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(1, 7, 0);
        cyc(0, 0, 0, 1, 7, 32'hDEAD, 0, 0, 7, 0);
        idle(3, 7, 0);

        // ALU starves the buffer until it fills, then drains in order
        cyc(1, 3, 32'h33, 1, 8, 32'h88, 0, 0, 0, 0);
        cyc(1, 3, 32'h34, 1, 9, 32'h99, 0, 0, 0, 0);
        cyc(1, 3, 32'h35, 1, 10, 32'hAA, 0, 0, 0, 0);
        idle(4, 0, 0);

        // Writes to x0 from both sources are ignored
        cyc(1, 0, 32'hFFFF, 1, 0, 32'hEEEE, 1, 0, 0, 0);
        cyc(1, 0, 32'h1111, 1, 0, 32'h2222, 0, 0, 0, 0);
        idle(2, 0, 0);

        // Issue to a register retiring at the same edge keeps it busy
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 0, 4);
        cyc(0, 0, 0, 1, 4, 32'h4444, 0, 0, 0, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 0, 4);
        idle(3, 0, 4);

        // Reset with a full buffer flushes it
        cyc(1, 3, 32'h1, 0, 0, 0, 1, 8, 8, 0);
        cyc(1, 3, 32'h2, 1, 8, 32'h8080, 0, 0, 8, 0);
        cyc(1, 3, 32'h3, 1, 9, 32'h9090, 0, 0, 8, 0);
        mid_reset(8);
        idle(4, 8, 9);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_reset(5'($urandom_range(0, 7)));
            end else begin
                cyc($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        idle(5, 0, 0);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
